// File: rtl/vote_controller.sv
// Voting-booth controller: synchronises and debounces four candidate buttons,
// arms one voter per poll-officer authorisation, emits one vote pulse per
// accepted press and enforces a lockout window between voters.
module vote_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned LOCKOUT_CYCLES  = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       voter_enable,
   input  logic       mode,
   input  logic [3:0] button,
   output logic       candidate1_vote_valid,
   output logic       candidate2_vote_valid,
   output logic       candidate3_vote_valid,
   output logic       candidate4_vote_valid,
   output logic       armed,
   output logic       busy,
   output logic       multi_press,
   output logic [9:0] votes_cast
);

   localparam int unsigned NUM_BUTTONS = 4;
   localparam int unsigned DB_W        = 8;
   localparam int unsigned LK_W        = 10;
   localparam int unsigned VC_W        = 10;
   localparam int unsigned NP_W        = 3;

   localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAST    = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_BUTTONS-1:0]  sync1_q, sync2_q;
   logic [DB_W-1:0]         db_cnt_q [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0]  pressed;
   logic                    activity;
   logic [NP_W-1:0]         n_pressed;
   logic [LK_W-1:0]         lock_q, lock_d;
   logic                    multi_seen_q, multi_seen_d;
   logic                    primed_q;
   logic [NUM_BUTTONS-1:0]  vote_q, vote_d;
   logic                    multi_d;
   logic                    count_inc;

   // Two-flop synchroniser for the asynchronous raw buttons
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= button;
         sync2_q <= sync1_q;
      end
   end

   // Per-button debounce counter: counts high samples, clears on low, saturates
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (reset || !sync2_q[i]) begin
            db_cnt_q[i] <= '0;
         end else if (db_cnt_q[i] != DB_MAX) begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
         end
      end
   end

   // Pressed flags, pressed count and any-activity indication
   always_comb begin
      pressed   = '0;
      n_pressed = '0;
      activity  = (|sync1_q) | (|sync2_q);
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         pressed[i] = (db_cnt_q[i] == DB_MAX);
         n_pressed  = n_pressed + NP_W'(pressed[i]);
         if (db_cnt_q[i] != '0) begin
            activity = 1'b1;
         end
      end
   end

   // Blocks arming on the first cycle out of reset, before the synchroniser
   // has seen a button that may be held through reset deassertion
   always_ff @(posedge clock) begin
      if (reset) begin
         primed_q <= 1'b0;
      end else begin
         primed_q <= 1'b1;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      lock_d       = lock_q;
      multi_seen_d = multi_seen_q;
      multi_d      = 1'b0;
      vote_d       = '0;
      count_inc    = 1'b0;

      case (state_q)
         IDLE: begin
            multi_seen_d = 1'b0;
            // Arm only once the buttons are fully quiet, so a held button
            // can never carry over into a new voter's session
            if (voter_enable && !mode && primed_q && !activity && (pressed == '0)) begin
               state_d = ARMED;
            end
         end

         ARMED: begin
            if (mode) begin
               state_d = IDLE;
            end else if (n_pressed == NP_W'(1)) begin
               state_d   = CAST;
               vote_d    = pressed;
               count_inc = 1'b1;
            end else if (n_pressed != '0) begin
               // Report a simultaneous press once until every button lets go
               if (!multi_seen_q) begin
                  multi_d      = 1'b1;
                  multi_seen_d = 1'b1;
               end
            end else begin
               multi_seen_d = 1'b0;
            end
         end

         CAST: begin
            state_d = LOCKOUT;
            lock_d  = LK_LOAD;
         end

         LOCKOUT: begin
            if (lock_q != '0) begin
               lock_d = lock_q - LK_W'(1);
            end else if (pressed == '0) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register, lockout counter and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         lock_q       <= '0;
         multi_seen_q <= 1'b0;
         vote_q       <= '0;
         armed        <= 1'b0;
         busy         <= 1'b0;
         multi_press  <= 1'b0;
         votes_cast   <= '0;
      end else begin
         state_q      <= state_d;
         lock_q       <= lock_d;
         multi_seen_q <= multi_seen_d;
         vote_q       <= vote_d;
         armed        <= (state_d == ARMED);
         busy         <= (state_d == CAST) || (state_d == LOCKOUT);
         multi_press  <= multi_d;
         if (count_inc) begin
            votes_cast <= votes_cast + VC_W'(1);
         end
      end
   end

   assign candidate1_vote_valid = vote_q[0];
   assign candidate2_vote_valid = vote_q[1];
   assign candidate3_vote_valid = vote_q[2];
   assign candidate4_vote_valid = vote_q[3];

endmodule

// File: tb/tb_vote_controller.sv
// Directed bench for vote_controller: main instance with default timing and a
// fast instance (short debounce and lockout) used for the counter wrap.
module tb_vote_controller;

   logic       clock;
   logic       reset;
   logic       voter_enable;
   logic       mode;
   logic [3:0] button;
   logic [3:0] button2;

   logic       c1, c2, c3, c4, armed, busy, multi_press;
   logic [9:0] votes_cast;
   logic       f1, f2, f3, f4, armed2, busy2, multi2;
   logic [9:0] votes2;

   int n_cmp = 0;
   int n_err = 0;

   int pulses [4];
   int first_pulse;
   int busy_n;
   int multi_n;
   int armed_low;
   int multi_hot;

   vote_controller dut (
      .clock                (clock),
      .reset                (reset),
      .voter_enable         (voter_enable),
      .mode                 (mode),
      .button               (button),
      .candidate1_vote_valid(c1),
      .candidate2_vote_valid(c2),
      .candidate3_vote_valid(c3),
      .candidate4_vote_valid(c4),
      .armed                (armed),
      .busy                 (busy),
      .multi_press          (multi_press),
      .votes_cast           (votes_cast)
   );

   vote_controller #(.DEBOUNCE_CYCLES(2), .LOCKOUT_CYCLES(1)) dut_fast (
      .clock                (clock),
      .reset                (reset),
      .voter_enable         (voter_enable),
      .mode                 (mode),
      .button               (button2),
      .candidate1_vote_valid(f1),
      .candidate2_vote_valid(f2),
      .candidate3_vote_valid(f3),
      .candidate4_vote_valid(f4),
      .armed                (armed2),
      .busy                 (busy2),
      .multi_press          (multi2),
      .votes_cast           (votes2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive a button pattern from a negedge and tally outputs for a window;
   // button released after rel_at cycles, mode raised after mode_at cycles
   task automatic run_window(input logic [3:0] pat, input int cycles,
                             input int rel_at, input int mode_at);
      logic [3:0] vv;
      button = pat;
      for (int k = 0; k < 4; k++) pulses[k] = 0;
      first_pulse = 0;
      busy_n      = 0;
      multi_n     = 0;
      armed_low   = 0;
      multi_hot   = 0;
      for (int i = 1; i <= cycles; i++) begin
         @(negedge clock);
         vv = {c4, c3, c2, c1};
         for (int k = 0; k < 4; k++) pulses[k] += int'(vv[k]);
         if ($countones(vv) > 1) multi_hot++;
         if (vv != 4'b0 && first_pulse == 0) first_pulse = i;
         busy_n    += int'(busy);
         multi_n   += int'(multi_press);
         armed_low += int'(!armed);
         if (i == rel_at)  button = 4'b0;
         if (i == mode_at) mode   = 1'b1;
      end
   endtask

   initial begin
      int   got_cast;
      int   wrap_pulses;
      logic ok;

      reset        = 1'b1;
      voter_enable = 1'b0;
      mode         = 1'b0;
      button       = 4'b0;
      button2      = 4'b0;
      repeat (3) @(negedge clock);
      check("reset_outputs", {c1, c2, c3, c4, armed, busy, multi_press, votes_cast}, 0);
      reset = 1'b0;

      // Arm the first voter
      voter_enable = 1'b1;
      repeat (3) @(negedge clock);
      check("armed_after_enable", armed, 1);

      // Single clean press of candidate 3
      run_window(4'b0100, 120, 20, 0);
      check("c3_pulses", pulses[2], 1);
      check("other_pulses_v1", pulses[0] + pulses[1] + pulses[3], 0);
      check("vote_latency", first_pulse, 19);
      check("busy_len_v1", busy_n, 65);
      check("votes_after_v1", votes_cast, 1);
      check("no_multi_v1", multi_n, 0);
      check("rearmed_v1", armed, 1);

      // Ten-cycle glitch never qualifies
      run_window(4'b0100, 40, 10, 0);
      check("glitch_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
      check("glitch_armed", armed_low, 0);
      check("glitch_votes", votes_cast, 1);

      // Simultaneous press is rejected with one multi_press pulse
      run_window(4'b0011, 40, 25, 0);
      check("multi_count", multi_n, 1);
      check("multi_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
      check("multi_armed", armed_low, 0);
      run_window(4'b0010, 100, 20, 0);
      check("c2_pulses", pulses[1], 1);
      check("c2_latency", first_pulse, 19);
      check("votes_after_v2", votes_cast, 2);

      // Button held well past lockout
      run_window(4'b0001, 320, 200, 0);
      check("held_c1_pulses", pulses[0], 1);
      check("held_busy_len", busy_n, 185);
      check("held_votes", votes_cast, 3);
      check("held_rearmed", armed, 1);
      check("onehot_so_far", multi_hot, 0);

      // mode=1 while armed returns to idle without a vote
      mode = 1'b1;
      @(negedge clock);
      check("mode_disarms", armed, 0);
      run_window(4'b0100, 40, 20, 0);
      check("mode_no_pulse", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
      check("mode_stays_idle", armed_low, 40);
      check("mode_votes", votes_cast, 3);
      mode = 1'b0;
      repeat (3) @(negedge clock);
      check("mode_rearm", armed, 1);

      // mode=1 during lockout neither aborts nor shortens it
      run_window(4'b1000, 120, 20, 30);
      check("lk_mode_c4", pulses[3], 1);
      check("lk_mode_busy", busy_n, 65);
      check("lk_mode_votes", votes_cast, 4);
      check("lk_mode_idle", armed, 0);
      mode = 1'b0;
      repeat (2) @(negedge clock);
      check("armed_before_rst", armed, 1);

      // Reset asserted while the vote pulse is up
      button   = 4'b0100;
      got_cast = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (c3) begin
            got_cast = 1;
            break;
         end
      end
      check("cast_before_rst", got_cast, 1);
      reset = 1'b1;
      @(negedge clock);
      check("rst_in_cast", {c1, c2, c3, c4, armed, busy, multi_press, votes_cast}, 0);

      // Button held through reset deassertion never arms until released
      reset = 1'b0;
      run_window(4'b0100, 40, 0, 0);
      check("held_rst_no_arm", armed_low, 40);
      check("held_rst_no_pulse", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
      check("held_rst_votes", votes_cast, 0);
      button = 4'b0;
      repeat (8) @(negedge clock);
      check("held_rst_release_arm", armed, 1);

      // Reset on the edge that would start CAST suppresses the pulse
      button = 4'b0100;
      repeat (18) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rst_at_cast_edge", {c1, c2, c3, c4, votes_cast}, 0);
      reset  = 1'b0;
      button = 4'b0;
      repeat (8) @(negedge clock);

      // 1024 votes on the fast instance wrap the counter
      wrap_pulses = 0;
      ok          = 1'b1;
      for (int v = 0; v < 1024 && ok; v++) begin
         ok = 1'b0;
         for (int i = 0; i < 30; i++) begin
            if (armed2) begin
               ok = 1'b1;
               break;
            end
            @(negedge clock);
         end
         if (!ok) begin
            check("wrap_arm_timeout", 0, 1);
            break;
         end
         if (v == 1023) check("votes_1023", votes2, 1023);
         button2 = 4'b0001;
         ok = 1'b0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (f1) begin
               ok = 1'b1;
               wrap_pulses++;
               break;
            end
         end
         button2 = 4'b0;
         if (!ok) check("wrap_pulse_timeout", 0, 1);
      end
      repeat (4) @(negedge clock);
      check("wrap_pulses", wrap_pulses, 1024);
      check("votes_wrap", votes2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vote_controller.md
VOTE_CONTROLLER -- requirements
Module: vote_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive high samples for a button to count as pressed (legal range 2..255).
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 64: minimum cycles from vote cast until the next voter may be armed (legal range 1..1023).
REQ-003 SHALL have port clock, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port voter_enable, input, 1: poll-officer authorisation for one voter, level-sampled.
REQ-006 SHALL have port mode, input, 1: 0 = voting, 1 = result display (voting inhibited).
REQ-007 SHALL have port button, input, 4: raw candidate buttons; bit i = candidate i+1; asynchronous to clock.
REQ-008 SHALL have port candidate1_vote_valid..candidate4_vote_valid, output, 1 each: one-cycle vote pulses to the vote logger.
REQ-009 SHALL have port armed, output, 1: high while in ARMED state (voter may press).
REQ-010 SHALL have port busy, output, 1: high in CAST and LOCKOUT.
REQ-011 SHALL have port multi_press, output, 1: one-cycle pulse on rejected simultaneous press.
REQ-012 SHALL have port votes_cast, output, 10: total accepted votes, wraps 1023->0.

Function
REQ-013 SHALL pass each button bit through a 2-flop synchroniser before debounce.
REQ-014 SHALL debounce per bit: counter increments while the synchronised bit is 1, clears to 0 when it is 0, saturates at DEBOUNCE_CYCLES; pressed[i] = (counter == DEBOUNCE_CYCLES).
REQ-015 SHALL implement FSM states IDLE, ARMED, CAST, LOCKOUT.
REQ-016 IDLE -> ARMED when voter_enable=1, mode=0 and no pressed[i] set; else stay IDLE.
REQ-017 ARMED -> CAST when exactly one pressed[i] is set; capture index i.
REQ-018 ARMED with two or more pressed bits set: no vote; pulse multi_press for exactly one cycle on first detection; stay ARMED; re-pulse only after all pressed bits clear.
REQ-019 ARMED -> IDLE, with no vote, if mode becomes 1.
REQ-020 CAST lasts exactly one cycle: assert the captured candidateN_vote_valid only; increment votes_cast; then -> LOCKOUT.
REQ-021 Vote pulse latency: candidateN_vote_valid high in the cycle after the FSM samples the single pressed bit in ARMED; raw press to pulse = 2 sync + DEBOUNCE_CYCLES + 1 cycles (max).
REQ-022 At most one candidateN_vote_valid SHALL be high in any cycle; all SHALL be 0 outside CAST.
REQ-023 LOCKOUT counts LOCKOUT_CYCLES cycles from CAST exit; -> IDLE only when the count has expired AND all pressed bits are 0; held buttons extend LOCKOUT indefinitely.
REQ-024 voter_enable held high through LOCKOUT SHALL NOT re-arm until IDLE is re-entered and REQ-016 is met (no carry-over vote).
REQ-025 mode changes during CAST or LOCKOUT SHALL NOT abort the cast vote or shorten lockout.
REQ-026 Button activity in IDLE or LOCKOUT SHALL produce no vote and no multi_press.

Reset
REQ-027 Reset SHALL force: state IDLE, all vote_valid 0, armed 0, busy 0, multi_press 0, votes_cast 0, debounce counters 0, synchronisers 0, lockout counter 0.
REQ-028 Reset asserted in any state, including CAST, SHALL suppress the pending vote pulse in the same cycle.
REQ-029 Button held through reset deassertion SHALL be re-debounced from 0 and SHALL NOT arm until released (REQ-016).

Verification
REQ-030 voter_enable=1, button=0100 held 20 cycles (DEBOUNCE_CYCLES=16) -> single candidate3_vote_valid pulse, votes_cast=1, busy high 65 cycles.
REQ-031 button=0100 glitching high 10 cycles then low -> no pulse, armed stays 1.
REQ-032 button=0011 simultaneously in ARMED -> multi_press one pulse, no vote; release then 0010 -> candidate2 pulse.
REQ-033 button held 200 cycles after vote -> exactly one pulse; IDLE re-entered only after release and lockout expiry.
REQ-034 mode=1 in ARMED -> IDLE, no pulse; mode=1 during LOCKOUT -> lockout completes unchanged.
REQ-035 1024 accepted votes -> votes_cast wraps to 0; reset during CAST -> no pulse, all outputs 0 next cycle.
